// File: rtl/cfi_pkg.sv
// Shared types and classification helpers for the commit-stage CFI marker checker.
package cfi_pkg;

  localparam int XLEN = 64;

  // Exception cause raised on a control-flow-integrity violation.
  localparam logic [XLEN-1:0] BREAKPOINT = 64'd3;

  typedef enum logic [3:0] {
    ADD, SUB, ANDL, ORL, JAL, JALR, LOAD, STORE
  } fu_op;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    fu_op            op;
    logic [4:0]      rs1;
    logic [4:0]      rd;
    logic [XLEN-1:0] result;
    exception_t      ex;
  } scoreboard_entry_t;

  // Encodings double as the pending_o value (00 none, 01 call, 10 return).
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    EXP_CALL = 2'b01,
    EXP_RET  = 2'b10
  } cfi_state_e;

  typedef enum logic [2:0] {
    OTHER, CALL, RET, MRK_CALL, MRK_RET
  } cfi_class_e;

  // Return: jalr x0, 0(ra).
  function automatic logic is_ret(fu_op op, logic [4:0] rd, logic [4:0] rs1);
    return (op == JALR) && (rd == 5'd0) && (rs1 == 5'd1);
  endfunction

  // Call: any jump that links.
  function automatic logic is_call(fu_op op, logic [4:0] rd);
    return ((op == JAL) || (op == JALR)) && (rd != 5'd0);
  endfunction

  // Marker: a NOP-like op writing x0 from x0, tagged by its immediate.
  function automatic logic is_marker(fu_op op, logic [4:0] rd, logic [4:0] rs1,
                                     logic [4:0] res, fu_op marker_op, logic [4:0] imm);
    return (op == marker_op) && (rd == 5'd0) && (rs1 == 5'd0) && (res == imm);
  endfunction

endpackage

// File: rtl/cfi_marker_checker_if.sv
// Commit-port bus carrying retirement strobes and the retiring scoreboard entries.
interface cfi_marker_checker_if
  import cfi_pkg::*;
#(
  parameter int NR_COMMIT_PORTS = 2
);
  logic              [NR_COMMIT_PORTS-1:0] commit_ack;
  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr;

  modport master (output commit_ack, output commit_instr);
  modport slave  (input  commit_ack, input  commit_instr);
endinterface

// File: rtl/cfi_classify.sv
// Purely combinational classifier for one retiring entry.
module cfi_classify
  import cfi_pkg::*;
#(
  parameter fu_op       MARKER_OP       = ADD,
  parameter logic [4:0] MARKER_IMM_CALL = 5'h2,
  parameter logic [4:0] MARKER_IMM_RET  = 5'h1
) (
  input  scoreboard_entry_t instr,
  output cfi_class_e        cls,
  output logic              trap
);

  // Fields the classifier has no use for.
  logic unused_fields;
  assign unused_fields = ^{instr.pc, instr.result[XLEN-1:5], instr.ex.cause, instr.ex.tval};

  // Priority classification; excepting entries never count as call/return.
  always_comb begin
    cls  = OTHER;
    trap = instr.ex.valid;
    if (!instr.ex.valid && is_ret(instr.op, instr.rd, instr.rs1))
      cls = RET;
    else if (!instr.ex.valid && is_call(instr.op, instr.rd))
      cls = CALL;
    else if (is_marker(instr.op, instr.rd, instr.rs1, instr.result[4:0], MARKER_OP, MARKER_IMM_CALL))
      cls = MRK_CALL;
    else if (is_marker(instr.op, instr.rd, instr.rs1, instr.result[4:0], MARKER_OP, MARKER_IMM_RET))
      cls = MRK_RET;
  end

endmodule

// File: rtl/cfi_marker_checker.sv
// Commit-stage CFI monitor: call/return marker pairing and nesting-depth checks.
module cfi_marker_checker
  import cfi_pkg::*;
#(
  parameter int         NR_COMMIT_PORTS = 2,
  parameter fu_op       MARKER_OP       = ADD,
  parameter logic [4:0] MARKER_IMM_CALL = 5'h2,
  parameter logic [4:0] MARKER_IMM_RET  = 5'h1,
  parameter int         MAX_DEPTH       = 64,
  parameter int         CNT_W           = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  cfi_marker_checker_if.slave              commit,
  output exception_t                       exception_o,
  output logic                             violation_o,
  output logic [$clog2(MAX_DEPTH+1)-1:0]   depth_o,
  output logic [CNT_W-1:0]                 viol_cnt_o,
  output logic [1:0]                       pending_o
);

  localparam int DW = $clog2(MAX_DEPTH+1);

  cfi_class_e [NR_COMMIT_PORTS-1:0] cls;
  logic       [NR_COMMIT_PORTS-1:0] trap;

  cfi_state_e      state_q, state_n;
  logic [DW-1:0]   depth_n;
  logic            viol_n;
  logic [XLEN-1:0] tval_n;

  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_cls
    cfi_classify #(
      .MARKER_OP       (MARKER_OP),
      .MARKER_IMM_CALL (MARKER_IMM_CALL),
      .MARKER_IMM_RET  (MARKER_IMM_RET)
    ) u_cls (
      .instr (commit.commit_instr[k]),
      .cls   (cls[k]),
      .trap  (trap[k])
    );
  end

  // State and depth registers.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst_i) begin
      state_q <= IDLE;
      depth_o <= '0;
    end else begin
      state_q <= state_n;
      depth_o <= depth_n;
    end
  end

  // Next-state scan across acked ports, oldest first, carrying state port to port.
  always_comb begin
    logic reclass;
    logic hit;
    // NOTE: every variable gets a default before the loop so no latch is inferred.
    state_n = state_q;
    depth_n = depth_o;
    viol_n  = 1'b0;
    tval_n  = '0;
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      reclass = 1'b0;
      hit     = 1'b0;
      if (commit.commit_ack[k]) begin
        unique case (state_n)
          EXP_CALL, EXP_RET: begin
            if (trap[k] ||
                (state_n == EXP_CALL && cls[k] == MRK_CALL) ||
                (state_n == EXP_RET  && cls[k] == MRK_RET)) begin
              state_n = IDLE;
            end else begin
              hit     = 1'b1;
              state_n = IDLE;
              reclass = 1'b1;
            end
          end
          default: reclass = 1'b1;
        endcase
        if (reclass && cls[k] == CALL) begin
          if (depth_n == DW'(MAX_DEPTH)) hit = 1'b1;
          else                           depth_n = depth_n + DW'(1);
          state_n = EXP_CALL;
        end else if (reclass && cls[k] == RET) begin
          if (depth_n == '0) hit = 1'b1;
          else               depth_n = depth_n - DW'(1);
          state_n = EXP_RET;
        end
        if (hit && !viol_n) tval_n = commit.commit_instr[k].pc;
        viol_n = viol_n | hit;
      end
    end
  end

  // Expectation state presented as the pending code.
  always_comb begin
    pending_o = state_q;
  end

  // Registered violation reporting, gated by enforcement enable.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exception_o <= '0;
      violation_o <= 1'b0;
      viol_cnt_o  <= '0;
    end else begin
      exception_o <= '0;
      violation_o <= 1'b0;
      if (en_i && viol_n) begin
        exception_o.valid <= 1'b1;
        exception_o.cause <= BREAKPOINT;
        exception_o.tval  <= tval_n;
        violation_o       <= 1'b1;
        if (viol_cnt_o != '1) viol_cnt_o <= viol_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cfi_marker_checker.sv
// Directed self-checking bench for cfi_marker_checker (2 ports, depth limit 4).
module tb_cfi_marker_checker;
  import cfi_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic en;
  exception_t exc;
  logic       viol;
  logic [2:0] depth;
  logic [15:0] cnt;
  logic [1:0]  pend;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cfi_marker_checker_if #(.NR_COMMIT_PORTS(2)) commit_bus ();

  cfi_marker_checker #(
    .NR_COMMIT_PORTS (2),
    .MARKER_OP       (ADD),
    .MARKER_IMM_CALL (5'h2),
    .MARKER_IMM_RET  (5'h1),
    .MAX_DEPTH       (4),
    .CNT_W           (16)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .commit      (commit_bus),
    .exception_o (exc),
    .violation_o (viol),
    .depth_o     (depth),
    .viol_cnt_o  (cnt),
    .pending_o   (pend)
  );

  function automatic scoreboard_entry_t mk(fu_op op, logic [4:0] rd, logic [4:0] rs1,
                                           logic [63:0] res, logic [63:0] pc, logic exv);
    scoreboard_entry_t e;
    e           = '0;
    e.op        = op;
    e.rd        = rd;
    e.rs1       = rs1;
    e.result    = res;
    e.pc        = pc;
    e.ex.valid  = exv;
    e.ex.cause  = exv ? 64'd2 : 64'd0;
    return e;
  endfunction

  function automatic scoreboard_entry_t call_e(logic [63:0] pc);
    return mk(JAL, 5'd1, 5'd0, pc + 64'd4, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t ret_e(logic [63:0] pc);
    return mk(JALR, 5'd0, 5'd1, 64'd0, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mcall_e(logic [63:0] pc);
    return mk(ADD, 5'd0, 5'd0, 64'd2, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t mret_e(logic [63:0] pc);
    return mk(ADD, 5'd0, 5'd0, 64'd1, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t add_e(logic [63:0] pc);
    return mk(ADD, 5'd5, 5'd3, 64'd7, pc, 1'b0);
  endfunction
  function automatic scoreboard_entry_t trap_e(logic [63:0] pc);
    return mk(ADD, 5'd5, 5'd3, 64'd0, pc, 1'b1);
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one window, let it be clocked in, return just after the edge.
  task automatic step(logic [1:0] ack, scoreboard_entry_t i0, scoreboard_entry_t i1);
    commit_bus.commit_ack      = ack;
    commit_bus.commit_instr[0] = i0;
    commit_bus.commit_instr[1] = i1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    scoreboard_entry_t nop;
    nop = '0;
    rst = 1'b1;
    en  = 1'b1;
    commit_bus.commit_ack   = '0;
    commit_bus.commit_instr = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    check("rst_exc_valid", 64'(exc.valid), 64'd0);
    check("rst_viol",      64'(viol),      64'd0);
    check("rst_depth",     64'(depth),     64'd0);
    check("rst_cnt",       64'(cnt),       64'd0);
    check("rst_pend",      64'(pend),      64'd0);

    // Call + matching marker in one window.
    step(2'b11, call_e(64'h100), mcall_e(64'h104));
    check("pair_exc_valid", 64'(exc.valid), 64'd0);
    check("pair_depth",     64'(depth),     64'd1);
    check("pair_pend",      64'(pend),      64'd0);

    // Return on port 1, then two idle cycles, then a non-marker.
    step(2'b10, nop, ret_e(64'h200));
    check("ret_depth", 64'(depth), 64'd0);
    check("ret_pend",  64'(pend),  64'd2);
    check("ret_viol",  64'(viol),  64'd0);
    step(2'b00, nop, nop);
    step(2'b00, nop, nop);
    check("idle_pend", 64'(pend), 64'd2);
    step(2'b01, add_e(64'h300), nop);
    check("miss_exc_valid", 64'(exc.valid), 64'd1);
    check("miss_cause",     exc.cause,      64'd3);
    check("miss_tval",      exc.tval,       64'h300);
    check("miss_viol",      64'(viol),      64'd1);
    check("miss_cnt",       64'(cnt),       64'd1);
    check("miss_pend",      64'(pend),      64'd0);
    step(2'b00, nop, nop);
    check("pulse_exc_valid", 64'(exc.valid), 64'd0);
    check("pulse_viol",      64'(viol),      64'd0);

    // Underflow: return at depth 0 with a correct marker.
    step(2'b11, ret_e(64'h400), mret_e(64'h404));
    check("uflow_viol",  64'(viol),  64'd1);
    check("uflow_tval",  exc.tval,   64'h400);
    check("uflow_depth", 64'(depth), 64'd0);
    check("uflow_pend",  64'(pend),  64'd0);
    check("uflow_cnt",   64'(cnt),   64'd2);

    // Overflow: five call+marker pairs against a limit of 4.
    for (int i = 0; i < 5; i++) begin
      step(2'b11, call_e(64'h500 + 64'(8*i)), mcall_e(64'h504 + 64'(8*i)));
      check("oflow_depth", 64'(depth), (i < 4) ? 64'(i + 1) : 64'd4);
      check("oflow_viol",  64'(viol),  (i < 4) ? 64'd0 : 64'd1);
    end
    check("oflow_tval", exc.tval,  64'h520);
    check("oflow_cnt",  64'(cnt),  64'd3);
    check("oflow_pend", 64'(pend), 64'd0);

    // Trap entry clears a pending call expectation silently.
    step(2'b11, ret_e(64'h600), mret_e(64'h604));
    check("down_depth", 64'(depth), 64'd3);
    step(2'b10, nop, call_e(64'h700));
    check("arm_pend",  64'(pend),  64'd1);
    check("arm_depth", 64'(depth), 64'd4);
    step(2'b01, trap_e(64'h704), nop);
    check("trap_viol", 64'(viol), 64'd0);
    check("trap_pend", 64'(pend), 64'd0);
    check("trap_cnt",  64'(cnt),  64'd3);

    // Enforcement off: overflow and mismatch are tracked but not reported.
    en = 1'b0;
    step(2'b01, call_e(64'h800), nop);
    check("dis_arm_pend", 64'(pend), 64'd1);
    check("dis_oflow_viol", 64'(viol), 64'd0);
    step(2'b01, add_e(64'h804), nop);
    check("dis_exc_valid", 64'(exc.valid), 64'd0);
    check("dis_viol",      64'(viol),      64'd0);
    check("dis_cnt",       64'(cnt),       64'd3);
    check("dis_pend",      64'(pend),      64'd0);
    en = 1'b1;

    // Two violations in one window: counter +1, tval from port 0, call re-arms.
    step(2'b11, ret_e(64'h900), mret_e(64'h904));
    step(2'b01, ret_e(64'hA00), nop);
    check("multi_pre_depth", 64'(depth), 64'd2);
    check("multi_pre_pend",  64'(pend),  64'd2);
    step(2'b11, call_e(64'hB00), add_e(64'hB04));
    check("multi_viol",  64'(viol),  64'd1);
    check("multi_tval",  exc.tval,   64'hB00);
    check("multi_cnt",   64'(cnt),   64'd4);
    check("multi_depth", 64'(depth), 64'd3);
    check("multi_pend",  64'(pend),  64'd0);

    // Reset while a call marker is pending, with a non-marker acked the same cycle.
    step(2'b01, call_e(64'hC00), nop);
    check("prerst_pend", 64'(pend), 64'd1);
    rst = 1'b1;
    step(2'b01, add_e(64'hC04), nop);
    rst = 1'b0;
    check("midrst_exc_valid", 64'(exc.valid), 64'd0);
    check("midrst_viol",      64'(viol),      64'd0);
    check("midrst_depth",     64'(depth),     64'd0);
    check("midrst_cnt",       64'(cnt),       64'd0);
    check("midrst_pend",      64'(pend),      64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cfi_marker_checker.md
# cfi_marker_checker

Commit-stage control-flow-integrity monitor for the Ariane core, generalised to any number of commit ports. It checks that every committed call is immediately followed in retirement order by a call-marker NOP, and every committed return by a return-marker NOP. It also tracks call/return nesting depth to flag return underflow and call overflow. Violations raise a registered BREAKPOINT exception toward the commit/CSR path, a violation pulse, and a saturating violation counter.

## Interface
- NR_COMMIT_PORTS, 2, number of commit ports scanned per cycle (1..4)
- MARKER_OP, ariane_pkg::ADD, fu_op of a marker instruction
- MARKER_IMM_CALL, 5'h2, result[4:0] identifying a call marker
- MARKER_IMM_RET, 5'h1, result[4:0] identifying a return marker
- MAX_DEPTH, 64, call-depth limit; depth counter width is $clog2(MAX_DEPTH+1)
- CNT_W, 16, width of the violation counter
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  enforcement enable (CSR bit); gates exception_o, violation_o and the counter only
- commit_ack_i  in  NR_COMMIT_PORTS  per-port retirement strobe; each asserted bit is one distinct retirement
- commit_instr_i  in  NR_COMMIT_PORTS x scoreboard_entry_t  retiring entries, port 0 oldest
- exception_o  out  exception_t  registered violation exception
- violation_o  out  1  one-cycle pulse per cycle with at least one enforced violation
- depth_o  out  $clog2(MAX_DEPTH+1)  current call depth
- viol_cnt_o  out  CNT_W  saturating count of violating cycles
- pending_o  out  2  current expectation state (00 none, 01 call marker, 10 return marker)

## Operation
- Classification per port, in priority order:
  - return: op JALR, rd==0, rs1==1
  - call: op JAL or JALR with rd!=0
  - marker-call / marker-ret: op MARKER_OP, rd==0, rs1==0, result[4:0] matches the corresponding immediate
  - other: anything else
- Window scan:
  - Only acked ports take part, processed in order 0..N-1.
  - State carries combinationally from port k to port k+1, then is registered at the end of the cycle.
- States:
  - IDLE: an acked call goes to EXP_CALL; an acked return goes to EXP_RET.
  - EXP_CALL: the next acked instruction must be marker-call. On a match, go to IDLE. Otherwise flag a violation and re-classify that instruction from IDLE, so a call immediately following still arms a new expectation.
  - EXP_RET: same as EXP_CALL, using marker-ret.
- Entries with ex.valid=1:
  - Never classified as call/return.
  - In EXP_* they clear the expectation without violation (trap entry).
- Depth counter:
  - Call increments; at MAX_DEPTH it holds and flags an overflow violation.
  - Return decrements; at 0 it holds and flags an underflow violation.
  - Several calls/returns in one window apply sequentially.
- Multiple violations in one window:
  - exception_o.tval carries the pc of the lowest-port offender.
  - The counter increments by 1.
- en_i=0: state and depth still track; no exception_o, violation_o or counter change.
- viol_cnt_o saturates at all-ones.

## Timing
- Outputs are registered; exception_o, violation_o and viol_cnt_o reflect window N at cycle N+1.
- exception_o: valid=1, cause=riscv::BREAKPOINT, tval=offender pc. It is a one-cycle pulse with no hold or handshake.
- depth_o and pending_o update at the clock edge following the window.
- A marker check spanning cycles (call on the last acked port, marker in a later cycle) is legal; idle cycles with no acks leave state unchanged.
- Reset values: state IDLE, depth 0, counter 0, exception_o all zero, violation_o 0, pending_o 00.
- rst_i dominates same-cycle acks. Reset mid-expectation drops the expectation without violation.

## Structure
- cfi_pkg holds:
  - the state enum (IDLE, EXP_CALL, EXP_RET)
  - the class enum (OTHER, CALL, RET, MRK_CALL, MRK_RET)
  - the classification functions is_call, is_ret and is_marker (the last parametrised by immediate)
- Sub-module cfi_classify: purely combinational per-port classifier, instantiated NR_COMMIT_PORTS times. The sequential scan, depth counter and output registers stay in cfi_marker_checker.

## Test plan
- Call on port 0, marker-call (result=2) on port 1, same cycle, en_i=1 -> no exception, depth_o 0->1, pending_o stays 00.
- Return on port 1 at cycle 0, plain ADD x5 on port 0 at cycle 3 -> exception_o.valid=1 at cycle 4, tval = ADD pc, viol_cnt_o=1, pending_o=00.
- Return with depth_o=0 followed by correct marker-ret -> underflow violation, depth_o stays 0, tval = return pc.
- MAX_DEPTH=4: five call+marker pairs -> fifth flags overflow, depth_o holds 4.
- Call pending, next acked entry has ex.valid=1 -> no violation, pending_o=00; same mismatch with en_i=0 -> no exception, counter unchanged.
- rst_i asserted while pending_o=01 with acked non-marker the same cycle -> next cycle all outputs at reset values, no exception.
